multi_cycle_ctrl: RTL and testbench
===================================

Name: multi_cycle_ctrl

Overview:
Multi-cycle control unit that sequences the PC, instruction register, register file, ALU and data memory through the IF/ID/EXE/MEM/WB phases. It drives the PC's PCWrite/PCSrc inputs so that the PC advances exactly once per retired instruction. It decodes the 6-bit opcode held in the IR together with the ALU Zero/Sign flags, and stops in HALT until reset.

Parameters:
CNT_W, 32, width of retired-instruction counter InstrCount.

Ports:
CLK  input  1  system clock, rising-edge active
Reset  input  1  asynchronous, active-low reset
Opcode  input  6  IR[31:26]; must be stable from ID through the instruction's last state
Zero  input  1  ALU result == 0, valid in EXE
Sign  input  1  ALU result[31], valid in EXE
State  output  3  current state, for debug
PCWrite  output  1  PC load enable
PCSrc  output  2  next PC select: 00 PC+4, 01 PC+4+(imm<<2), 10 rs (jr), 11 {PC[31:28],addr,2'b00}
IRWrite  output  1  IR load enable
RegWrite  output  1  register file write enable
RegDst  output  2  write register: 00 $31, 01 rt, 10 rd
WrRegDSrc  output  1  register write data: 0 PC+4, 1 DB
ALUSrcA  output  1  0 rs, 1 sa
ALUSrcB  output  1  0 rt, 1 extended immediate
ALUOp  output  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 101 slt
ExtSel  output  1  0 zero-extend, 1 sign-extend
MemRead  output  1  data memory read enable
MemWrite  output  1  data memory write enable
DBDataSrc  output  1  0 ALU result, 1 memory data
InstrCount  output  CNT_W  number of retired instructions
Halted  output  1  high in HALT

Behaviour:
- Reset is asynchronous and active-low. While Reset=0: State=IF, InstrCount=0, and PCWrite, IRWrite, RegWrite, MemWrite and MemRead are all forced to 0. All other outputs are 0.
- State encoding: IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=111. Any other code goes to IF on the next edge.
- Transitions:
  - IF -> ID, always.
  - ID -> IF for j, jal, jr. ID -> HALT for halt. ID -> EXE otherwise.
  - EXE -> IF for beq, bne, bltz. EXE -> MEM for lw, sw. EXE -> WB otherwise.
  - MEM -> WB for lw. MEM -> IF for sw.
  - WB -> IF.
  - HALT -> HALT until Reset.
- Latency per instruction: jumps 2 cycles, branches 3, sw 4, R-type/immediate ALU 4, lw 5.
- Control outputs are combinational from State and Opcode.
- IRWrite=1 only in IF.
- PCWrite=1 only in the last state of an instruction: ID for jumps, EXE for branches, MEM for sw, WB for all others. It is never 1 in IF or HALT.
- PCSrc selection:
  - 01 for a taken branch: beq&Zero, bne&~Zero, bltz&Sign. A not-taken branch uses 00.
  - 10 for jr; 11 for j and jal; 00 otherwise.
- jal asserts RegWrite in ID with RegDst=00 and WrRegDSrc=0.
- RegWrite in WB:
  - RegDst=10 for R-type; 01 for immediate ops and lw.
  - WrRegDSrc=1 in WB.
- MemRead=1 in MEM for lw. MemWrite=1 in MEM for sw.
- DBDataSrc=1 for lw in MEM/WB.
- ExtSel=1 for addiu, lw, sw, beq, bne, bltz; 0 for andi, ori.
- ALUSrcB=1 for addiu, andi, ori, lw, sw. ALUSrcA=1 for sll only.
- ALUOp: sub for beq/bne/bltz and sub; or for ori; and for and/andi; slt for slt; sll for sll; add otherwise.
- InstrCount increments by 1 on every edge where PCWrite=1, and wraps modulo 2^CNT_W.
- Unknown opcode: treated as a 4-cycle no-op. No RegWrite or MemWrite is issued; PCWrite=1 with PCSrc=00 in WB.
- Reset asserted mid-instruction: the partial instruction is abandoned, no write enables remain active, and fetch restarts at IF.

Decomposition:
- Shared package cpu_defs_pkg holds the opcode constants: add 000000, sub 000001, addiu 000010, and 010000, andi 010001, ori 010010, slt 011000, sll 011100, sw 100110, lw 100111, beq 110000, bne 110001, bltz 110010, j 111000, jr 111001, jal 111010, halt 111111.
- The package also holds the state codes and the ALUOp and PCSrc encodings.
- One sub-module, ctrl_decode, is natural: the combinational State+Opcode+flags -> control-word decode. The FSM and counter live in the top.

Test Plan:
- Reset=0 for 100 ns, then release; Opcode=add -> State walks IF, ID, EXE, WB, IF. PCWrite=1 only in WB with PCSrc=00 and RegDst=10; InstrCount=1.
- Opcode=beq with Zero=1 in EXE -> PCWrite=1 and PCSrc=01 in EXE, next State=IF. Repeat with Zero=0 -> PCSrc=00.
- Opcode=lw -> 5-cycle path IF/ID/EXE/MEM/WB. MemRead=1 in MEM, DBDataSrc=1, RegWrite=1 with RegDst=01 in WB. Opcode=sw -> MemWrite=1 in MEM, then IF, no RegWrite.
- Opcode=jal -> in ID: RegWrite=1, RegDst=00, PCWrite=1, PCSrc=11. Opcode=jr -> PCSrc=10. Both are 2 cycles each.
- Opcode=halt -> State=111 and Halted=1, PCWrite stays 0 for 20 cycles, InstrCount is frozen.
- Assert Reset in MEM of sw, asynchronously mid-cycle -> MemWrite drops immediately, State=IF, InstrCount=0.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared encodings for the multi-cycle controller: opcodes, state codes,
// ALU/PC select codes and the decoded control word.
package cpu_defs_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLT   = 6'b011000;
  localparam logic [5:0] OP_SLL   = 6'b011100;
  localparam logic [5:0] OP_SW    = 6'b100110;
  localparam logic [5:0] OP_LW    = 6'b100111;
  localparam logic [5:0] OP_BEQ   = 6'b110000;
  localparam logic [5:0] OP_BNE   = 6'b110001;
  localparam logic [5:0] OP_BLTZ  = 6'b110010;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  typedef enum logic [2:0] {
    ST_IF   = 3'b000,
    ST_ID   = 3'b001,
    ST_EXE  = 3'b010,
    ST_MEM  = 3'b011,
    ST_WB   = 3'b100,
    ST_HALT = 3'b111
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b11;

  localparam logic [1:0] RD_RA = 2'b00;
  localparam logic [1:0] RD_RT = 2'b01;
  localparam logic [1:0] RD_RD = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic       wr_reg_d_src;
    logic       alu_src_a;
    logic       alu_src_b;
    logic [2:0] alu_op;
    logic       ext_sel;
    logic       mem_read;
    logic       mem_write;
    logic       db_data_src;
  } ctrl_t;

  function automatic logic is_jump(input logic [5:0] op);
    return (op == OP_J) || (op == OP_JR) || (op == OP_JAL);
  endfunction

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLTZ);
  endfunction

  function automatic logic is_rtype(input logic [5:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_SLT) || (op == OP_SLL);
  endfunction

  function automatic logic is_imm_wr(input logic [5:0] op);
    return (op == OP_ADDIU) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_LW);
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath bundle: decoded opcode/flags in, control word out.
interface multi_cycle_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0]       Opcode;
  logic             Zero;
  logic             Sign;
  logic [2:0]       State;
  logic             PCWrite;
  logic [1:0]       PCSrc;
  logic             IRWrite;
  logic             RegWrite;
  logic [1:0]       RegDst;
  logic             WrRegDSrc;
  logic             ALUSrcA;
  logic             ALUSrcB;
  logic [2:0]       ALUOp;
  logic             ExtSel;
  logic             MemRead;
  logic             MemWrite;
  logic             DBDataSrc;
  logic [CNT_W-1:0] InstrCount;
  logic             Halted;

  modport master (
    input  Opcode, Zero, Sign,
    output State, PCWrite, PCSrc, IRWrite, RegWrite, RegDst, WrRegDSrc,
           ALUSrcA, ALUSrcB, ALUOp, ExtSel, MemRead, MemWrite, DBDataSrc,
           InstrCount, Halted
  );

  modport slave (
    output Opcode, Zero, Sign,
    input  State, PCWrite, PCSrc, IRWrite, RegWrite, RegDst, WrRegDSrc,
           ALUSrcA, ALUSrcB, ALUOp, ExtSel, MemRead, MemWrite, DBDataSrc,
           InstrCount, Halted
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational State+Opcode+flags -> control word. en_i low forces every
// output to zero so nothing is enabled while the controller is held in reset.
module ctrl_decode
  import cpu_defs_pkg::*;
(
  input  logic       en_i,
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic       zero_i,
  input  logic       sign_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    if (en_i) begin
      case (opcode_i)
        OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: ctrl_o.alu_op = ALU_SUB;
        OP_ORI:                          ctrl_o.alu_op = ALU_OR;
        OP_AND, OP_ANDI:                 ctrl_o.alu_op = ALU_AND;
        OP_SLT:                          ctrl_o.alu_op = ALU_SLT;
        OP_SLL:                          ctrl_o.alu_op = ALU_SLL;
        default:                         ctrl_o.alu_op = ALU_ADD;
      endcase
      ctrl_o.ext_sel   = opcode_i inside {OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BLTZ};
      ctrl_o.alu_src_b = opcode_i inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_LW, OP_SW};
      ctrl_o.alu_src_a = (opcode_i == OP_SLL);

      // PC select only matters on the cycle PCWrite is raised
      if (opcode_i == OP_JR)
        ctrl_o.pc_src = PC_JR;
      else if (opcode_i == OP_J || opcode_i == OP_JAL)
        ctrl_o.pc_src = PC_JMP;
      else if ((opcode_i == OP_BEQ && zero_i) || (opcode_i == OP_BNE && !zero_i) ||
               (opcode_i == OP_BLTZ && sign_i))
        ctrl_o.pc_src = PC_BR;

      case (state_i)
        ST_IF:  ctrl_o.ir_write = 1'b1;
        ST_ID: begin
          ctrl_o.pc_write  = is_jump(opcode_i);
          ctrl_o.reg_write = (opcode_i == OP_JAL);
          ctrl_o.reg_dst   = RD_RA;
        end
        ST_EXE: ctrl_o.pc_write = is_branch(opcode_i);
        ST_MEM: begin
          ctrl_o.mem_read    = (opcode_i == OP_LW);
          ctrl_o.mem_write   = (opcode_i == OP_SW);
          ctrl_o.db_data_src = (opcode_i == OP_LW);
          ctrl_o.pc_write    = (opcode_i == OP_SW);
        end
        ST_WB: begin
          ctrl_o.pc_write     = 1'b1;
          ctrl_o.wr_reg_d_src = 1'b1;
          ctrl_o.db_data_src  = (opcode_i == OP_LW);
          if (is_rtype(opcode_i)) begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.reg_dst   = RD_RD;
          end else if (is_imm_wr(opcode_i)) begin
            ctrl_o.reg_write = 1'b1;
            ctrl_o.reg_dst   = RD_RT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle controller: phase FSM plus retired-instruction counter.
//   state | meaning
//   IF    | fetch, IR load
//   ID    | decode; jumps retire here
//   EXE   | ALU op; branches retire here
//   MEM   | data memory access; sw retires here
//   WB    | register write-back; remaining instructions retire here
//   HALT  | stopped until reset
module multi_cycle_ctrl
  import cpu_defs_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic               CLK,
  input logic               Reset,
  multi_cycle_ctrl_if.master bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  ctrl_t            ctrl;

  ctrl_decode u_decode (
    .en_i     (Reset),
    .state_i  (state_q),
    .opcode_i (bus.Opcode),
    .zero_i   (bus.Zero),
    .sign_i   (bus.Sign),
    .ctrl_o   (ctrl)
  );

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IF;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = ST_IF;
    count_d = ctrl.pc_write ? count_q + CNT_W'(1) : count_q;
    case (state_q)
      ST_IF:  state_d = ST_ID;
      ST_ID: begin
        if (is_jump(bus.Opcode))       state_d = ST_IF;
        else if (bus.Opcode == OP_HALT) state_d = ST_HALT;
        else                           state_d = ST_EXE;
      end
      ST_EXE: begin
        if (is_branch(bus.Opcode))                           state_d = ST_IF;
        else if (bus.Opcode == OP_LW || bus.Opcode == OP_SW) state_d = ST_MEM;
        else                                                 state_d = ST_WB;
      end
      ST_MEM:  state_d = (bus.Opcode == OP_LW) ? ST_WB : ST_IF;
      ST_WB:   state_d = ST_IF;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IF;
    endcase
  end

  assign bus.State      = state_q;
  assign bus.PCWrite    = ctrl.pc_write;
  assign bus.PCSrc      = ctrl.pc_src;
  assign bus.IRWrite    = ctrl.ir_write;
  assign bus.RegWrite   = ctrl.reg_write;
  assign bus.RegDst     = ctrl.reg_dst;
  assign bus.WrRegDSrc  = ctrl.wr_reg_d_src;
  assign bus.ALUSrcA    = ctrl.alu_src_a;
  assign bus.ALUSrcB    = ctrl.alu_src_b;
  assign bus.ALUOp      = ctrl.alu_op;
  assign bus.ExtSel     = ctrl.ext_sel;
  assign bus.MemRead    = ctrl.mem_read;
  assign bus.MemWrite   = ctrl.mem_write;
  assign bus.DBDataSrc  = ctrl.db_data_src;
  assign bus.InstrCount = count_q;
  assign bus.Halted     = (state_q == ST_HALT);

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed and random instruction streams against a per-instruction model
// built from phase lists, latencies and the opcode control table.
module tb_multi_cycle_ctrl;
  import cpu_defs_pkg::*;

  localparam int CW = 4;

  logic CLK = 1'b0;
  logic Reset = 1'b0;
  int n_assert = 0;
  int n_fail = 0;
  logic [CW-1:0] cnt_m = '0;

  multi_cycle_ctrl_if #(.CNT_W(CW)) bus ();
  multi_cycle_ctrl #(.CNT_W(CW)) dut (.CLK(CLK), .Reset(Reset), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_len(input logic [5:0] op);
    if (op inside {OP_J, OP_JR, OP_JAL}) return 2;
    if (op inside {OP_BEQ, OP_BNE, OP_BLTZ}) return 3;
    if (op == OP_LW) return 5;
    return 4;
  endfunction

  function automatic logic [2:0] m_state(input logic [5:0] op, input int k);
    case (k)
      0: return 3'b000;
      1: return 3'b001;
      2: return 3'b010;
      3: return (op == OP_LW || op == OP_SW) ? 3'b011 : 3'b100;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] m_alu(input logic [5:0] op);
    if (op inside {OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ}) return 3'b001;
    if (op == OP_ORI) return 3'b011;
    if (op inside {OP_AND, OP_ANDI}) return 3'b100;
    if (op == OP_SLT) return 3'b101;
    if (op == OP_SLL) return 3'b010;
    return 3'b000;
  endfunction

  function automatic logic [1:0] m_pcsrc(input logic [5:0] op, input logic z, input logic s);
    if (op == OP_JR) return 2'b10;
    if (op == OP_J || op == OP_JAL) return 2'b11;
    if ((op == OP_BEQ && z) || (op == OP_BNE && !z) || (op == OP_BLTZ && s)) return 2'b01;
    return 2'b00;
  endfunction

  task automatic run_instr(input logic [5:0] op, input logic z, input logic s);
    int len;
    logic [2:0] st;
    logic rw, wb_writer;
    len = m_len(op);
    wb_writer = op inside {OP_ADD, OP_SUB, OP_AND, OP_SLT, OP_SLL,
                           OP_ADDIU, OP_ANDI, OP_ORI, OP_LW};
    bus.Opcode = op; bus.Zero = z; bus.Sign = s;
    #1;
    for (int k = 0; k < len; k++) begin
      st = m_state(op, k);
      rw = (op == OP_JAL && k == 1) || (st == 3'b100 && wb_writer);
      chk("state", bus.State, st);
      chk("pcwrite", bus.PCWrite, k == len - 1);
      chk("irwrite", bus.IRWrite, k == 0);
      chk("regwrite", bus.RegWrite, rw);
      chk("memread", bus.MemRead, st == 3'b011 && op == OP_LW);
      chk("memwrite", bus.MemWrite, st == 3'b011 && op == OP_SW);
      if (rw) begin
        chk("regdst", bus.RegDst,
            (op == OP_JAL) ? 2'b00 : (op inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_LW}) ? 2'b01 : 2'b10);
        chk("wrregdsrc", bus.WrRegDSrc, op != OP_JAL);
      end
      if (k == len - 1) chk("pcsrc", bus.PCSrc, m_pcsrc(op, z, s));
      if (st == 3'b010) begin
        chk("aluop", bus.ALUOp, m_alu(op));
        chk("alusrcb", bus.ALUSrcB, op inside {OP_ADDIU, OP_ANDI, OP_ORI, OP_LW, OP_SW});
        chk("alusrca", bus.ALUSrcA, op == OP_SLL);
        if (op inside {OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_BLTZ, OP_ANDI, OP_ORI})
          chk("extsel", bus.ExtSel, !(op inside {OP_ANDI, OP_ORI}));
      end
      if (op == OP_LW && (st == 3'b011 || st == 3'b100)) chk("dbdatasrc", bus.DBDataSrc, 1);
      @(negedge CLK); #1;
    end
    cnt_m = cnt_m + 1'b1;
    chk("instrcount", bus.InstrCount, cnt_m);
    chk("halted", bus.Halted, 0);
  endtask

  initial begin
    logic [5:0] ops [16];
    logic [5:0] op;
    int idx;
    ops = '{OP_ADD, OP_SUB, OP_ADDIU, OP_AND, OP_ANDI, OP_ORI, OP_SLT, OP_SLL,
            OP_SW, OP_LW, OP_BEQ, OP_BNE, OP_BLTZ, OP_J, OP_JR, OP_JAL};
    bus.Opcode = OP_ADD; bus.Zero = 1'b0; bus.Sign = 1'b0;
    #50;
    chk("rst_state", bus.State, 3'b000);
    chk("rst_irwrite", bus.IRWrite, 0);
    chk("rst_pcwrite", bus.PCWrite, 0);
    chk("rst_count", bus.InstrCount, 0);
    chk("rst_halted", bus.Halted, 0);
    #50;
    Reset = 1'b1;

    run_instr(OP_ADD, 0, 0);
    run_instr(OP_BEQ, 1, 0);
    run_instr(OP_BEQ, 0, 0);
    run_instr(OP_LW, 0, 0);
    run_instr(OP_SW, 0, 0);
    run_instr(OP_JAL, 0, 0);
    run_instr(OP_JR, 0, 0);
    run_instr(OP_J, 0, 0);
    run_instr(OP_BNE, 0, 0);
    run_instr(OP_BNE, 1, 1);
    run_instr(OP_BLTZ, 0, 1);
    run_instr(OP_BLTZ, 1, 0);
    run_instr(OP_SLL, 0, 0);
    run_instr(OP_ORI, 0, 0);
    run_instr(6'b101010, 0, 0);

    for (int n = 0; n < 60; n++) begin
      idx = $urandom_range(0, 17);
      if (idx >= 16) op = (idx == 16) ? 6'b000111 : 6'b110111;
      else op = ops[idx];
      run_instr(op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    bus.Opcode = OP_HALT;
    #1;
    chk("halt_if", bus.State, 3'b000);
    @(negedge CLK); #1;
    chk("halt_id", bus.State, 3'b001);
    chk("halt_id_pcwrite", bus.PCWrite, 0);
    for (int n = 0; n < 20; n++) begin
      @(negedge CLK); #1;
      chk("halt_state", bus.State, 3'b111);
      chk("halt_flag", bus.Halted, 1);
      chk("halt_pcwrite", bus.PCWrite, 0);
      chk("halt_count", bus.InstrCount, cnt_m);
    end

    Reset = 1'b0;
    cnt_m = '0;
    #1;
    chk("rst2_state", bus.State, 3'b000);
    chk("rst2_count", bus.InstrCount, 0);
    @(negedge CLK);
    Reset = 1'b1;
    bus.Opcode = OP_SW;
    for (int n = 0; n < 3; n++) @(negedge CLK);
    #1;
    chk("sw_mem_state", bus.State, 3'b011);
    chk("sw_mem_write", bus.MemWrite, 1);
    #2;
    Reset = 1'b0;
    #1;
    chk("midrst_memwrite", bus.MemWrite, 0);
    chk("midrst_pcwrite", bus.PCWrite, 0);
    chk("midrst_irwrite", bus.IRWrite, 0);
    chk("midrst_state", bus.State, 3'b000);
    chk("midrst_count", bus.InstrCount, 0);
    @(negedge CLK);
    Reset = 1'b1;
    run_instr(OP_ADD, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
